// File: rtl/axi_trace_pkg.sv
// axi_trace_pkg: capture-mode encodings and entry-width helper shared by the AXI address tracer.
package axi_trace_pkg;
  localparam logic [1:0] MODE_VRA = 2'd0;
  localparam logic [1:0] MODE_V   = 2'd1;
  localparam logic [1:0] MODE_R   = 2'd2;
  localparam logic [1:0] MODE_VRO = 2'd3;
  function automatic int entry_w(input int ts_w, input int addr_w);
    return ts_w + addr_w;
  endfunction
endpackage

// File: rtl/axi_trace_chan.sv
// axi_trace_chan: one channel of the tracer -- event decode, trace buffer, pointers, count, overflow, readback mux.
module axi_trace_chan
  import axi_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int EW = entry_w(TS_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              valid,
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              wrap_en,
  input  logic              clear,
  input  logic [TS_W-1:0]   ts,
  input  logic [IW-1:0]     rd_idx,
  output logic [EW-1:0]     entry,
  output logic              hit,
  output logic [CW-1:0]     count,
  output logic              ovf
);
  logic [EW-1:0] mem [DEPTH];
  logic [IW-1:0] wptr, ridx;
  logic          cond, ev, full, wr;
  assign cond = mode == MODE_VRA ? valid & ready :
                mode == MODE_V   ? valid :
                mode == MODE_R   ? ready : valid | ready;
  assign ev   = en & cond;
  assign full = count == CW'(DEPTH);
  assign wr   = ev & ~clear & (~full | wrap_en);
  // Once full, the write pointer also marks the oldest entry.
  assign ridx  = (full ? wptr : '0) + rd_idx;
  assign hit   = CW'(rd_idx) < count;
  assign entry = hit ? mem[ridx] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {ts, addr};
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (ev) begin
      if (wr) wptr <= wptr + IW'(1);
      if (!full) count <= count + CW'(1);
      if (full) ovf <= 1'b1;
    end
endmodule

// File: rtl/axi_addr_trace.sv
// axi_addr_trace: timestamped trace of AXI AW/AR addresses with registered indexed readback.
module axi_addr_trace
  import axi_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_x,
  input  logic                         awvalid,
  input  logic                         awready,
  input  logic                         arvalid,
  input  logic                         arready,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         wrap_en,
  input  logic                         clear,
  input  logic                         rd_sel,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic [TS_W+ADDR_W-1:0]       rd_data,
  output logic                         rd_hit,
  output logic [$clog2(DEPTH+1)-1:0]   aw_count,
  output logic [$clog2(DEPTH+1)-1:0]   ar_count,
  output logic                         aw_ovf,
  output logic                         ar_ovf
);
  localparam int EW = entry_w(TS_W, ADDR_W);
  logic [TS_W-1:0] ts;
  logic [EW-1:0]   aw_entry, ar_entry;
  logic            aw_hit, ar_hit;
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      ts      <= '0;
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      ts      <= ts + TS_W'(1);
      rd_data <= rd_sel ? ar_entry : aw_entry;
      rd_hit  <= rd_sel ? ar_hit : aw_hit;
    end
  axi_trace_chan #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)) u_aw (
    .clk(clk), .rst_x(rst_x), .valid(awvalid), .ready(awready), .addr(awaddr),
    .en(en), .mode(mode), .wrap_en(wrap_en), .clear(clear), .ts(ts), .rd_idx(rd_idx),
    .entry(aw_entry), .hit(aw_hit), .count(aw_count), .ovf(aw_ovf)
  );
  axi_trace_chan #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)) u_ar (
    .clk(clk), .rst_x(rst_x), .valid(arvalid), .ready(arready), .addr(araddr),
    .en(en), .mode(mode), .wrap_en(wrap_en), .clear(clear), .ts(ts), .rd_idx(rd_idx),
    .entry(ar_entry), .hit(ar_hit), .count(ar_count), .ovf(ar_ovf)
  );
endmodule

// File: tb/tb_axi_addr_trace.sv
// tb_axi_addr_trace: directed and randomized checks of axi_addr_trace against a queue-based trace model.
module tb_axi_addr_trace;
  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        awvalid = 0, awready = 0, arvalid = 0, arready = 0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic        en = 0, wrap_en = 0, clear = 0, rd_sel = 0;
  logic [1:0]  mode = 0;
  logic [3:0]  rd_idx = 0;
  logic [47:0] rd_data;
  logic        rd_hit, aw_ovf, ar_ovf;
  logic [4:0]  aw_count, ar_count;
  int checks = 0, errs = 0;
  logic [47:0] q[2][$];
  bit          movf[2];
  logic [15:0] ts_m = '0;
  always #5 clk = ~clk;
  axi_addr_trace dut (
    .clk(clk), .rst_x(rst_x), .awvalid(awvalid), .awready(awready), .arvalid(arvalid),
    .arready(arready), .awaddr(awaddr), .araddr(araddr), .en(en), .mode(mode),
    .wrap_en(wrap_en), .clear(clear), .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_hit(rd_hit), .aw_count(aw_count), .ar_count(ar_count), .aw_ovf(aw_ovf), .ar_ovf(ar_ovf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic bit fires(input logic [1:0] m, input logic v, input logic r);
    case (m)
      2'd0: return v && r;
      2'd1: return v;
      2'd2: return r;
      default: return v || r;
    endcase
  endfunction
  function automatic logic [47:0] exp_rd(input bit sel, input int idx);
    return idx < q[sel].size() ? q[sel][idx] : 48'h0;
  endfunction
  task automatic reset_model();
    for (int c = 0; c < 2; c++) begin
      q[c].delete();
      movf[c] = 0;
    end
    ts_m = '0;
  endtask
  task automatic step();
    bit          ev[2];
    logic [47:0] e[2];
    bit          clr, wr;
    ev[0] = en && fires(mode, awvalid, awready);
    ev[1] = en && fires(mode, arvalid, arready);
    e[0] = {ts_m, awaddr};
    e[1] = {ts_m, araddr};
    clr = clear;
    wr = wrap_en;
    @(posedge clk);
    for (int c = 0; c < 2; c++)
      if (clr) begin
        q[c].delete();
        movf[c] = 0;
      end else if (ev[c]) begin
        if (q[c].size() < 16) q[c].push_back(e[c]);
        else begin
          movf[c] = 1;
          if (wr) begin
            void'(q[c].pop_front());
            q[c].push_back(e[c]);
          end
        end
      end
    ts_m++;
    #1;
  endtask
  task automatic aw_ev(input logic [31:0] a);
    awvalid = 1; awready = 1; awaddr = a;
    step();
    awvalid = 0; awready = 0;
  endtask
  task automatic rd(input bit sel, input logic [3:0] idx);
    logic [47:0] e;
    bit          h;
    rd_sel = sel; rd_idx = idx;
    e = exp_rd(sel, int'(idx));
    h = int'(idx) < q[sel].size();
    step();
    chk("rd_data", rd_data, e);
    chk("rd_hit", rd_hit, h);
  endtask
  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask
  initial begin
    logic [15:0] t0;
    #3;
    chk("rst_aw_count", aw_count, 0);
    chk("rst_ar_count", ar_count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_hit", rd_hit, 0);
    chk("rst_ovf", {aw_ovf, ar_ovf}, 0);
    @(negedge clk);
    rst_x = 1;
    reset_model();
    #1;
    // handshake-only capture
    en = 1; mode = 0;
    aw_ev(32'h1000); aw_ev(32'h1004); aw_ev(32'h1008);
    awvalid = 1; awaddr = 32'hDEAD;
    step();
    awvalid = 0;
    chk("hs_aw_count", aw_count, 3);
    chk("hs_ar_count", ar_count, 0);
    for (int i = 0; i < 3; i++) begin
      rd(0, 4'(i));
      chk("hs_addr", rd_data[31:0], 32'h1000 + 32'(4 * i));
    end
    // valid-only capture on AR
    do_clear();
    mode = 1; arvalid = 1; arready = 0; araddr = 32'h2000;
    repeat (5) step();
    arvalid = 0;
    chk("v_ar_count", ar_count, 5);
    chk("v_ar_ovf", ar_ovf, 0);
    // stop-when-full and wrap
    for (int w = 0; w < 2; w++) begin
      do_clear();
      mode = 0; wrap_en = w[0];
      for (int i = 0; i < 20; i++) aw_ev(32'(i));
      chk("full_count", aw_count, 16);
      chk("full_ovf", aw_ovf, 1);
      rd(0, 0);
      chk("full_idx0", rd_data[31:0], w ? 4 : 0);
      rd(0, 15);
      chk("full_idx15", rd_data[31:0], w ? 19 : 15);
    end
    // clear wins over a simultaneous event
    clear = 1; awvalid = 1; awready = 1; awaddr = 32'h55;
    step();
    clear = 0; awvalid = 0; awready = 0;
    chk("clr_count", aw_count, 0);
    chk("clr_ovf", aw_ovf, 0);
    // timestamp spacing and out-of-range readback
    wrap_en = 0;
    aw_ev(32'hA0); step(); aw_ev(32'hA1); step(); aw_ev(32'hA2);
    rd(0, 0);
    t0 = rd_data[47:32];
    rd(0, 1);
    chk("ts_delta", rd_data[47:32] - t0, 2);
    rd(0, 5);
    chk("oob_data", rd_data, 0);
    chk("oob_hit", rd_hit, 0);
    // randomized traffic on both channels
    for (int n = 0; n < 400; n++) begin
      logic [47:0] e;
      bit          h;
      awvalid = 1'($urandom); awready = 1'($urandom);
      arvalid = 1'($urandom); arready = 1'($urandom);
      awaddr = $urandom; araddr = $urandom;
      mode = 2'($urandom); en = ($urandom % 8) != 0; wrap_en = 1'($urandom);
      clear = ($urandom % 60) == 0;
      rd_sel = 1'($urandom); rd_idx = 4'($urandom);
      e = exp_rd(rd_sel, int'(rd_idx));
      h = int'(rd_idx) < q[rd_sel].size();
      step();
      chk("rnd_rd_data", rd_data, e);
      chk("rnd_rd_hit", rd_hit, h);
      chk("rnd_aw_count", aw_count, q[0].size());
      chk("rnd_ar_count", ar_count, q[1].size());
      chk("rnd_aw_ovf", aw_ovf, movf[0]);
      chk("rnd_ar_ovf", ar_ovf, movf[1]);
    end
    // asynchronous reset mid-capture
    clear = 0; en = 1; mode = 3; awvalid = 1; arvalid = 1; rd_sel = 0; rd_idx = 0;
    step(); step();
    #2 rst_x = 0;
    #1;
    chk("arst_aw_count", aw_count, 0);
    chk("arst_ar_count", ar_count, 0);
    chk("arst_ovf", {aw_ovf, ar_ovf}, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_rd_hit", rd_hit, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/axi_addr_trace.md
AXI_ADDR_TRACE -- requirements
Module: axi_addr_trace

Interface
REQ-001 Parameter: ADDR_W, 32, address width of the AW and AR channels.
REQ-002 Parameter: DEPTH, 16, entries per channel trace buffer; power of two, minimum 2.
REQ-003 Parameter: TS_W, 16, timestamp width.
REQ-004 Port: clk  in  1  clock.
REQ-005 Port: rst_x  in  1  reset, asynchronous, active-low.
REQ-006 Port: awvalid, awready, arvalid, arready  in  1 each  monitored AXI handshake signals.
REQ-007 Port: awaddr, araddr  in  ADDR_W each  monitored addresses.
REQ-008 Port: en  in  1  capture enable.
REQ-009 Port: mode  in  2  capture condition: 0 = valid&ready, 1 = valid, 2 = ready, 3 = valid|ready.
REQ-010 Port: wrap_en  in  1  1 = circular overwrite; 0 = stop when full.
REQ-011 Port: clear  in  1  synchronous clear of both channels.
REQ-012 Port: rd_sel  in  1  readback channel select: 0 = AW, 1 = AR.
REQ-013 Port: rd_idx  in  clog2(DEPTH)  readback index; 0 = oldest valid entry.
REQ-014 Port: rd_data  out  TS_W+ADDR_W  {timestamp, address} of the selected entry.
REQ-015 Port: rd_hit  out  1  rd_idx is below the selected channel's count.
REQ-016 Port: aw_count, ar_count  out  clog2(DEPTH+1) each  number of valid entries.
REQ-017 Port: aw_ovf, ar_ovf  out  1 each  sticky flag: an event was dropped or an entry overwritten.

Function
REQ-018 A free-running TS_W timestamp shall increment every cycle from 0 after reset and wrap modulo 2^TS_W.
REQ-019 A channel event shall be the mode-selected condition ANDed with en, evaluated on the channel's own signals in the same cycle.
REQ-020 On an event, the entry {timestamp, addr} for that cycle shall be written at buf[wptr], and wptr shall advance modulo DEPTH at the next clk edge.
REQ-021 While count < DEPTH, each event shall increment count by 1.
REQ-022 With count == DEPTH and wrap_en = 0, an event shall be dropped, leave wptr and count unchanged, and set ovf.
REQ-023 With count == DEPTH and wrap_en = 1, an event shall overwrite the oldest entry, advance wptr, hold count at DEPTH, and set ovf.
REQ-024 The oldest entry shall be at physical index 0 while count < DEPTH, and at wptr once count == DEPTH.
REQ-025 Readback shall return buf[(oldest + rd_idx) mod DEPTH] of the selected channel on rd_data, registered with 1-cycle latency; rd_hit shall be registered alongside it.
REQ-026 When rd_idx >= count, rd_hit shall be 0 and rd_data shall be 0.
REQ-027 clear shall zero count, wptr and ovf on both channels at the next edge; it shall take priority over a simultaneous event, which is dropped. Buffer contents need not be cleared.
REQ-028 A change to mode, en or wrap_en shall affect events from the next cycle; entries already captured are unaffected.
REQ-029 The AW and AR channels shall operate independently; simultaneous events on both shall both be captured.

Reset
REQ-030 On rst_x low, the following shall be zero immediately (asynchronous): timestamp, wptr, count and ovf on both channels, rd_data, and rd_hit. Buffer RAM need not be reset.

Structure
REQ-031 Package axi_trace_pkg shall hold the mode encoding constants (MODE_VRA, MODE_V, MODE_R, MODE_VRO) and the entry-width helper.
REQ-032 Sub-module axi_trace_chan shall implement one channel (event decode, buffer, pointers, count, ovf, readback mux); it is instantiated twice, for AW and AR.

Verification
REQ-033 mode=0, en=1: AW handshakes at 0x1000, 0x1004, 0x1008, plus one valid-only cycle at 0xDEAD -> aw_count=3; idx0..2 read 0x1000, 0x1004, 0x1008; ar_count=0.
REQ-034 mode=1: arvalid=1, arready=0 for 5 cycles at 0x2000 -> ar_count=5, ar_ovf=0.
REQ-035 DEPTH=16, wrap_en=0: 20 AW events with addresses 0..19 -> aw_count=16, aw_ovf=1, idx0=0, idx15=15.
REQ-036 DEPTH=16, wrap_en=1: 20 AW events with addresses 0..19 -> aw_count=16, aw_ovf=1, idx0=4, idx15=19.
REQ-037 Timestamps: events 2 cycles apart -> stored timestamps differ by 2. With count=3, rd_idx=5 -> rd_hit=0 and rd_data=0 one cycle later.
REQ-038 clear asserted in the same cycle as an event -> count=0 and ovf=0 next cycle. rst_x low mid-capture -> counts, ovf and rd_data are 0 without waiting for a clk edge.
